// File: rtl/tea_stream_core_if.sv
// Stream-side bundle for tea_stream_core: block input, key/mode controls, result output.
interface tea_stream_core_if;
  logic         i_valid;
  logic         o_ready;
  logic [63:0]  i_data;
  logic [127:0] i_key;
  logic         i_decrypt;
  logic         i_xtea;
  logic         i_cbc;
  logic [63:0]  i_iv;
  logic         i_iv_load;
  logic         o_valid;
  logic         i_ready;
  logic [63:0]  o_data;
  logic         o_busy;

  // Core side
  modport slave (
    input  i_valid, i_data, i_key, i_decrypt, i_xtea, i_cbc, i_iv, i_iv_load, i_ready,
    output o_ready, o_valid, o_data, o_busy
  );

  // Source/sink side
  modport master (
    output i_valid, i_data, i_key, i_decrypt, i_xtea, i_cbc, i_iv, i_iv_load, i_ready,
    input  o_ready, o_valid, o_data, o_busy
  );
endinterface

// File: rtl/tea_stream_core.sv
// Streaming TEA/XTEA block cipher, encrypt/decrypt, ECB/CBC, UNROLL Feistel cycles per clock.
module tea_stream_core #(
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned UNROLL = 1,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  tea_stream_core_if.slave   bus
);

  localparam int unsigned STEPS   = ROUNDS / UNROLL;
  localparam int unsigned CW      = $clog2(STEPS + 1);
  localparam logic [31:0] SUM_DEC = 32'(64'(DELTA) * 64'(ROUNDS));

  generate
    if (ROUNDS == 0 || ROUNDS > 64 || UNROLL == 0 || (ROUNDS % UNROLL) != 0) begin : g_bad_cfg
      $error("tea_stream_core: ROUNDS must be 1..64 and a multiple of UNROLL");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_v0, r_v1, r_sum;
  logic [127:0]  r_key;
  logic          r_dec, r_xtea, r_cbc;
  logic [63:0]   r_in;
  logic [63:0]   r_chain;
  logic          r_ready, r_valid, r_busy;
  logic [63:0]   r_odata;

  logic [95:0]   w_st;
  logic [63:0]   w_res;
  logic [63:0]   w_out;
  logic [63:0]   w_iv;
  logic [63:0]   w_in_blk;
  logic          w_accept;

  function automatic logic [31:0] f_key(input logic [127:0] key, input logic [1:0] idx);
    logic [31:0] k;
    case (idx)
      2'd0:    k = key[127:96];
      2'd1:    k = key[95:64];
      2'd2:    k = key[63:32];
      default: k = key[31:0];
    endcase
    return k;
  endfunction

  // One Feistel cycle on {v0, v1, sum} for the selected algorithm and direction.
  function automatic logic [95:0] f_step(input logic [95:0] st, input logic [127:0] key,
                                         input logic dec, input logic xtea);
    logic [31:0] v0, v1, s;
    v0 = st[95:64];
    v1 = st[63:32];
    s  = st[31:0];
    case ({xtea, dec})
      2'b00: begin
        s  = s + DELTA;
        v0 = v0 + (((v1 << 4) + key[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + key[95:64]));
        v1 = v1 + (((v0 << 4) + key[63:32])  ^ (v0 + s) ^ ((v0 >> 5) + key[31:0]));
      end
      2'b01: begin
        v1 = v1 - (((v0 << 4) + key[63:32])  ^ (v0 + s) ^ ((v0 >> 5) + key[31:0]));
        v0 = v0 - (((v1 << 4) + key[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + key[95:64]));
        s  = s - DELTA;
      end
      2'b10: begin
        v0 = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + f_key(key, s[1:0])));
        s  = s + DELTA;
        v1 = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + f_key(key, s[12:11])));
      end
      default: begin
        v1 = v1 - ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + f_key(key, s[12:11])));
        s  = s - DELTA;
        v0 = v0 - ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + f_key(key, s[1:0])));
      end
    endcase
    return {v0, v1, s};
  endfunction

  // Unrolled round datapath for the current clock.
  always_comb begin
    w_st = {r_v0, r_v1, r_sum};
    for (int unsigned i = 0; i < UNROLL; i++) begin
      w_st = f_step(w_st, r_key, r_dec, r_xtea);
    end
  end

  assign w_res    = w_st[95:32];
  assign w_out    = (r_cbc && r_dec) ? (w_res ^ r_chain) : w_res;
  assign w_iv     = bus.i_iv_load ? bus.i_iv : r_chain;
  assign w_in_blk = (bus.i_cbc && !bus.i_decrypt) ? (bus.i_data ^ w_iv) : bus.i_data;
  assign w_accept = bus.i_valid && r_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_v0    <= '0;
      r_v1    <= '0;
      r_sum   <= '0;
      r_key   <= '0;
      r_dec   <= 1'b0;
      r_xtea  <= 1'b0;
      r_cbc   <= 1'b0;
      r_in    <= '0;
      r_chain <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_odata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_iv_load) r_chain <= bus.i_iv;
          if (w_accept) begin
            r_v0    <= w_in_blk[63:32];
            r_v1    <= w_in_blk[31:0];
            r_sum   <= bus.i_decrypt ? SUM_DEC : 32'd0;
            r_key   <= bus.i_key;
            r_dec   <= bus.i_decrypt;
            r_xtea  <= bus.i_xtea;
            r_cbc   <= bus.i_cbc;
            r_in    <= bus.i_data;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          {r_v0, r_v1, r_sum} <= w_st;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(STEPS - 1)) begin
            r_odata <= w_out;
            r_valid <= 1'b1;
            r_state <= S_DONE;
            // Chain always follows the ciphertext side of the block.
            if (r_cbc) r_chain <= r_dec ? r_in : w_res;
          end
        end
        S_DONE: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready = r_ready;
  assign bus.o_valid = r_valid;
  assign bus.o_busy  = r_busy;
  assign bus.o_data  = r_odata;

endmodule

// File: tb/tb_tea_stream_core.sv
// Directed scoreboard bench for tea_stream_core: reference TEA/XTEA model, three parameter builds.
module tb_tea_stream_core;

  localparam logic [31:0] D = 32'h9E3779B9;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  tea_stream_core_if bus ();
  tea_stream_core_if bus4 ();
  tea_stream_core_if bus16 ();

  tea_stream_core #(.ROUNDS(32), .UNROLL(1)) dut   (.i_clk(clk), .i_rstn(rstn), .bus(bus));
  tea_stream_core #(.ROUNDS(32), .UNROLL(4)) dut4  (.i_clk(clk), .i_rstn(rstn), .bus(bus4));
  tea_stream_core #(.ROUNDS(16), .UNROLL(2)) dut16 (.i_clk(clk), .i_rstn(rstn), .bus(bus16));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [63:0] sb[$];

  logic [63:0]  iv, p1, p2, p3, c1, c2, c3, pr, cr;
  logic [127:0] key, key2;

  // Textbook TEA/XTEA reference, whole block at once.
  function automatic logic [63:0] model(input logic [63:0] blk, input logic [127:0] k128,
                                        input logic dec, input logic xtea, input int unsigned rounds);
    logic [31:0] v0, v1, sum;
    logic [31:0] k [4];
    k[0] = k128[127:96]; k[1] = k128[95:64]; k[2] = k128[63:32]; k[3] = k128[31:0];
    v0 = blk[63:32];
    v1 = blk[31:0];
    sum = dec ? D * rounds : 32'd0;
    for (int unsigned r = 0; r < rounds; r++) begin
      if (!xtea && !dec) begin
        sum += D;
        v0 += ((v1 << 4) + k[0]) ^ (v1 + sum) ^ ((v1 >> 5) + k[1]);
        v1 += ((v0 << 4) + k[2]) ^ (v0 + sum) ^ ((v0 >> 5) + k[3]);
      end else if (!xtea) begin
        v1 -= ((v0 << 4) + k[2]) ^ (v0 + sum) ^ ((v0 >> 5) + k[3]);
        v0 -= ((v1 << 4) + k[0]) ^ (v1 + sum) ^ ((v1 >> 5) + k[1]);
        sum -= D;
      end else if (!dec) begin
        v0 += (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]);
        sum += D;
        v1 += (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]);
      end else begin
        v1 -= (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]);
        sum -= D;
        v0 -= (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]);
      end
    end
    return {v0, v1};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic init_bus(input virtual tea_stream_core_if vif);
    vif.i_valid = 1'b0; vif.i_data = '0; vif.i_key = '0; vif.i_decrypt = 1'b0;
    vif.i_xtea = 1'b0; vif.i_cbc = 1'b0; vif.i_iv = '0; vif.i_iv_load = 1'b0; vif.i_ready = 1'b0;
  endtask

  task automatic scramble(input virtual tea_stream_core_if vif);
    vif.i_data    = {$urandom, $urandom};
    vif.i_key     = {$urandom, $urandom, $urandom, $urandom};
    vif.i_decrypt = 1'($urandom_range(0, 1));
    vif.i_xtea    = 1'($urandom_range(0, 1));
    vif.i_cbc     = 1'($urandom_range(0, 1));
    vif.i_iv      = {$urandom, $urandom};
    vif.i_iv_load = 1'($urandom_range(0, 1));
  endtask

  // Accept one block, measure latency, optionally backpressure, then drain and score it.
  task automatic run_block(input virtual tea_stream_core_if vif, input logic [63:0] data,
                           input logic [127:0] k128, input logic dec, input logic xtea,
                           input logic cbc, input logic ivl, input logic [63:0] ivv,
                           input logic [63:0] exp, input int lat_exp, input int hold,
                           input string tag);
    int lat;
    logic [63:0] prev, want;
    check({tag, " ready"}, 64'(vif.o_ready), 64'd1);
    vif.i_data = data; vif.i_key = k128; vif.i_decrypt = dec; vif.i_xtea = xtea;
    vif.i_cbc = cbc; vif.i_iv_load = ivl; vif.i_iv = ivv; vif.i_valid = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    vif.i_valid = 1'b0;
    check({tag, " busy"}, 64'(vif.o_busy), 64'd1);
    lat = 0;
    while (vif.o_valid !== 1'b1 && lat < 200) begin
      scramble(vif);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(lat_exp));
    for (int h = 0; h < hold; h++) begin
      prev = vif.o_data;
      scramble(vif);
      @(posedge clk); #1;
      check({tag, " hold data"}, vif.o_data, prev);
      check({tag, " hold ready"}, 64'(vif.o_ready), 64'd0);
    end
    vif.i_iv_load = 1'b0;
    vif.i_ready = 1'b1;
    want = sb.pop_front();
    check({tag, " data"}, vif.o_data, want);
    @(posedge clk); #1;
    vif.i_ready = 1'b0;
    check({tag, " valid drop"}, 64'(vif.o_valid), 64'd0);
  endtask

  initial begin
    init_bus(bus); init_bus(bus4); init_bus(bus16);
    repeat (2) @(posedge clk);
    #1;
    check("rst ready", 64'(bus.o_ready), 64'd1);
    check("rst valid", 64'(bus.o_valid), 64'd0);
    check("rst busy",  64'(bus.o_busy),  64'd0);
    check("rst data",  bus.o_data,       64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_block(bus, 64'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0,
              64'h41EA3A0A_94BAA940, 32, 10, "tea_zero");
    run_block(bus, 64'd0, 128'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0,
              64'hDEE9D4D8_F7131ED9, 32, 0, "xtea_zero");
    run_block(bus, 64'hDEE9D4D8_F7131ED9, 128'd0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0,
              64'd0, 32, 0, "xtea_dec");

    key = {$urandom, $urandom, $urandom, $urandom};
    pr  = {$urandom, $urandom};
    cr  = model(pr, key, 1'b0, 1'b0, 32);
    run_block(bus, pr, key, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, cr, 32, 2, "tea_rand_enc");
    run_block(bus, cr, key, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, pr, 32, 0, "tea_rand_dec");

    // CBC chain of three, then reload IV and unwind it.
    iv = 64'h0123456789ABCDEF;
    p1 = {$urandom, $urandom}; p2 = {$urandom, $urandom}; p3 = {$urandom, $urandom};
    c1 = model(p1 ^ iv, key, 1'b0, 1'b0, 32);
    c2 = model(p2 ^ c1, key, 1'b0, 1'b0, 32);
    c3 = model(p3 ^ c2, key, 1'b0, 1'b0, 32);
    run_block(bus, p1, key, 1'b0, 1'b0, 1'b1, 1'b1, iv, c1, 32, 3, "cbc_enc1");
    run_block(bus, p2, key, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, c2, 32, 0, "cbc_enc2");
    run_block(bus, p3, key, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, c3, 32, 0, "cbc_enc3");
    run_block(bus, c1, key, 1'b1, 1'b0, 1'b1, 1'b1, iv, p1, 32, 0, "cbc_dec1");
    run_block(bus, c2, key, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, p2, 32, 2, "cbc_dec2");
    run_block(bus, c3, key, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, p3, 32, 0, "cbc_dec3");

    // Abort a block at round count 5; chain must come back as zero.
    bus.i_data = p1; bus.i_key = key; bus.i_decrypt = 1'b0; bus.i_xtea = 1'b0;
    bus.i_cbc = 1'b1; bus.i_iv_load = 1'b0; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    check("abort ready", 64'(bus.o_ready), 64'd1);
    check("abort valid", 64'(bus.o_valid), 64'd0);
    check("abort busy",  64'(bus.o_busy),  64'd0);
    check("abort data",  bus.o_data,       64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("abort no output", 64'(bus.o_valid), 64'd0);

    pr = {$urandom, $urandom};
    run_block(bus, pr, key, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0,
              model(pr, key, 1'b0, 1'b0, 32), 32, 0, "post_rst_cbc");
    key2 = {$urandom, $urandom, $urandom, $urandom};
    run_block(bus, pr, key2, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0,
              model(pr, key2, 1'b0, 1'b1, 32), 32, 0, "xtea_rand_enc");

    run_block(bus4, 64'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0,
              64'h41EA3A0A_94BAA940, 8, 0, "u4_tea_zero");

    pr = {$urandom, $urandom};
    cr = model(pr, key2, 1'b0, 1'b0, 16);
    run_block(bus16, pr, key2, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, cr, 8, 0, "r16_enc");
    run_block(bus16, cr, key2, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, pr, 8, 0, "r16_dec");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
